// File: rtl/fetch_stage_if.sv
// ---------------------------------------------------------------------------
// fetch_stage_if
// Bundles the fetch stage's bus-side signals: decode control (stall/flush/
// branch_target), the instruction ROM port (rom_ce/inst_addr/inst) and the
// IF/ID pipeline register outputs (id_valid/id_pc/id_inst/id_adel).
//   master : the fetch stage itself
//   slave  : the environment (decode/branch logic and the instruction ROM)
// ---------------------------------------------------------------------------
interface fetch_stage_if;
    logic        stall;
    logic        flush;
    logic [31:0] branch_target;
    logic        rom_ce;
    logic [31:0] inst_addr;
    logic [31:0] inst;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_adel;

    modport master (
        input  stall, flush, branch_target, inst,
        output rom_ce, inst_addr, id_valid, id_pc, id_inst, id_adel
    );

    modport slave (
        output stall, flush, branch_target, inst,
        input  rom_ce, inst_addr, id_valid, id_pc, id_inst, id_adel
    );
endinterface

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
// Instruction-fetch stage: owns the PC, drives the instruction ROM and
// registers each returned word into the IF/ID pipeline register. A redirect
// to a misaligned target produces one address-error entry in IF/ID and then
// suspends fetching until the next redirect.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous, active-high reset
//   bus  : fetch_stage_if.master (stall, flush, branch_target, inst in;
//          rom_ce, inst_addr, id_valid, id_pc, id_inst, id_adel out)
// ---------------------------------------------------------------------------
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          rst,
    fetch_stage_if.master bus
);

    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_ERR   = 2'd2
    } state_t;

    state_t      state_r,    state_s;
    logic [31:0] pc_r,       pc_s;
    logic        id_valid_r, id_valid_s;
    logic [31:0] id_pc_r,    id_pc_s;
    logic [31:0] id_inst_r,  id_inst_s;
    logic        id_adel_r,  id_adel_s;

    function automatic logic is_word_aligned(input logic [31:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

    // Next-state and IF/ID update; defaults hold every register.
    always_comb begin
        state_s    = state_r;
        pc_s       = pc_r;
        id_valid_s = id_valid_r;
        id_pc_s    = id_pc_r;
        id_inst_s  = id_inst_r;
        id_adel_s  = id_adel_r;
        case (state_r)
            S_IDLE: begin
                // One settling cycle after reset; decode requests are ignored.
                state_s = S_FETCH;
            end
            S_FETCH: begin
                if (bus.flush) begin
                    // Redirect wins over stall; the edge inserts a bubble.
                    pc_s       = bus.branch_target;
                    id_valid_s = 1'b0;
                    id_inst_s  = ZERO_WORD;
                    id_adel_s  = 1'b0;
                end else if (bus.stall) begin
                    state_s = S_FETCH;
                end else if (is_word_aligned(pc_r)) begin
                    id_pc_s    = pc_r;
                    id_inst_s  = bus.inst;
                    id_valid_s = 1'b1;
                    id_adel_s  = 1'b0;
                    pc_s       = pc_r + 32'd4;
                end else begin
                    // ROM was not enabled, so the word is replaced by zero.
                    id_pc_s    = pc_r;
                    id_inst_s  = ZERO_WORD;
                    id_valid_s = 1'b1;
                    id_adel_s  = 1'b1;
                    state_s    = S_ERR;
                end
            end
            S_ERR: begin
                if (bus.flush) begin
                    pc_s       = bus.branch_target;
                    id_valid_s = 1'b0;
                    id_inst_s  = ZERO_WORD;
                    id_adel_s  = 1'b0;
                    state_s    = S_FETCH;
                end else if (bus.stall) begin
                    state_s = S_ERR;
                end else begin
                    // Decode has taken the error entry; leave a bubble behind.
                    id_valid_s = 1'b0;
                    id_inst_s  = ZERO_WORD;
                    id_adel_s  = 1'b0;
                end
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // PC and IF/ID pipeline register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_r       <= RESET_PC;
            id_valid_r <= 1'b0;
            id_pc_r    <= ZERO_WORD;
            id_inst_r  <= ZERO_WORD;
            id_adel_r  <= 1'b0;
        end else begin
            pc_r       <= pc_s;
            id_valid_r <= id_valid_s;
            id_pc_r    <= id_pc_s;
            id_inst_r  <= id_inst_s;
            id_adel_r  <= id_adel_s;
        end
    end

    // ROM enable depends only on registered state so decode inputs never
    // reach the ROM in the same cycle.
    assign bus.rom_ce    = (state_r == S_FETCH) && is_word_aligned(pc_r);
    assign bus.inst_addr = pc_r;
    assign bus.id_valid  = id_valid_r;
    assign bus.id_pc     = id_pc_r;
    assign bus.id_inst   = id_inst_r;
    assign bus.id_adel   = id_adel_r;

endmodule

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage
// Directed startup/stall/flush/misalign/wrap/async-reset steps followed by a
// random stall/flush run, all compared against a behavioural model of the
// fetch stage and a model ROM.
// ---------------------------------------------------------------------------
module tb_fetch_stage;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    fetch_stage_if bus();

    fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Model ROM: every address maps to a distinct word.
    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF ^ {a[31:16], 16'h0000};
    endfunction

    assign bus.inst = bus.rom_ce ? rom_word(bus.inst_addr) : 32'h0000_0000;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model state
    bit          m_started;
    bit          m_halted;
    logic [31:0] m_pc;
    logic        m_valid;
    logic [31:0] m_id_pc;
    logic [31:0] m_id_inst;
    logic        m_adel;

    task automatic model_reset();
        m_started = 1'b0;
        m_halted  = 1'b0;
        m_pc      = 32'h0000_0000;
        m_valid   = 1'b0;
        m_id_pc   = 32'h0000_0000;
        m_id_inst = 32'h0000_0000;
        m_adel    = 1'b0;
    endtask

    task automatic model_bubble();
        m_valid   = 1'b0;
        m_id_inst = 32'h0000_0000;
        m_adel    = 1'b0;
    endtask

    task automatic model_step(input bit st, input bit fl, input logic [31:0] bt);
        if (!m_started) begin
            m_started = 1'b1;
        end else if (fl) begin
            m_pc     = bt;
            m_halted = 1'b0;
            model_bubble();
        end else if (st) begin
            // nothing moves
        end else if (m_halted) begin
            model_bubble();
        end else if (m_pc[1:0] == 2'b00) begin
            m_id_pc   = m_pc;
            m_id_inst = rom_word(m_pc);
            m_valid   = 1'b1;
            m_adel    = 1'b0;
            m_pc      = m_pc + 32'd4;
        end else begin
            m_id_pc   = m_pc;
            m_id_inst = 32'h0000_0000;
            m_valid   = 1'b1;
            m_adel    = 1'b1;
            m_halted  = 1'b1;
        end
    endtask

    function automatic logic model_rom_ce();
        return m_started && !m_halted && (m_pc[1:0] == 2'b00);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".rom_ce"},    {31'd0, bus.rom_ce},   {31'd0, model_rom_ce()});
        chk({tag, ".inst_addr"}, bus.inst_addr,         m_pc);
        chk({tag, ".id_valid"},  {31'd0, bus.id_valid}, {31'd0, m_valid});
        chk({tag, ".id_pc"},     bus.id_pc,             m_id_pc);
        chk({tag, ".id_inst"},   bus.id_inst,           m_id_inst);
        chk({tag, ".id_adel"},   {31'd0, bus.id_adel},  {31'd0, m_adel});
    endtask

    // Apply inputs, take one edge, compare #1 after it.
    task automatic cycle(input string tag, input bit st, input bit fl, input logic [31:0] bt);
        bus.stall         = st;
        bus.flush         = fl;
        bus.branch_target = bt;
        @(posedge clk);
        model_step(st, fl, bt);
        #1;
        check_all(tag);
    endtask

    initial begin
        logic [31:0] bt;
        bit          st;
        bit          fl;
        int          r;

        n_checks          = 0;
        n_fail            = 0;
        rst               = 1'b1;
        bus.stall         = 1'b0;
        bus.flush         = 1'b0;
        bus.branch_target = 32'h0000_0000;
        model_reset();

        // Reset held for three edges
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check_all("reset");
        end
        rst = 1'b0;

        // Startup: idle cycle, then pc 0,4,8
        cycle("idle", 1'b0, 1'b0, 32'h0);
        chk("startup_rom_ce", {31'd0, bus.rom_ce}, 32'd1);
        cycle("fetch0", 1'b0, 1'b0, 32'h0);
        chk("startup_pc0", bus.id_pc, 32'h0000_0000);
        cycle("fetch4", 1'b0, 1'b0, 32'h0);
        cycle("fetch8", 1'b0, 1'b0, 32'h0);
        chk("startup_pc8", bus.id_pc, 32'h0000_0008);

        // Stall three cycles, then continue 12, 16
        for (int i = 0; i < 3; i++) begin
            cycle("stall", 1'b1, 1'b0, 32'h0);
            chk("stall_addr", bus.inst_addr, 32'h0000_000C);
        end
        cycle("resume12", 1'b0, 1'b0, 32'h0);
        chk("resume_pc12", bus.id_pc, 32'h0000_000C);
        cycle("resume16", 1'b0, 1'b0, 32'h0);

        // Flush together with stall at inst_addr 20
        chk("pre_flush_addr", bus.inst_addr, 32'h0000_0014);
        cycle("flush_stall", 1'b1, 1'b1, 32'h0000_0100);
        chk("flush_valid", {31'd0, bus.id_valid}, 32'd0);
        cycle("target", 1'b0, 1'b0, 32'h0);
        chk("target_pc", bus.id_pc, 32'h0000_0100);

        // Misaligned redirect, error entry, suspension, recovery
        cycle("mis_flush", 1'b0, 1'b1, 32'h0000_0102);
        chk("mis_rom_ce", {31'd0, bus.rom_ce}, 32'd0);
        cycle("mis_entry", 1'b0, 1'b0, 32'h0);
        chk("mis_adel", {31'd0, bus.id_adel}, 32'd1);
        cycle("mis_consumed", 1'b0, 1'b0, 32'h0);
        cycle("err_stall", 1'b1, 1'b0, 32'h0);
        cycle("err_idle", 1'b0, 1'b0, 32'h0);
        cycle("recover", 1'b0, 1'b1, 32'h0000_0180);
        cycle("recover_fetch", 1'b0, 1'b0, 32'h0);
        chk("recover_pc", bus.id_pc, 32'h0000_0180);

        // Wrap-around
        cycle("wrap_flush", 1'b0, 1'b1, 32'hFFFF_FFF8);
        cycle("wrap0", 1'b0, 1'b0, 32'h0);
        cycle("wrap1", 1'b0, 1'b0, 32'h0);
        chk("wrap_pc_fffc", bus.id_pc, 32'hFFFF_FFFC);
        cycle("wrap2", 1'b0, 1'b0, 32'h0);
        chk("wrap_pc_0", bus.id_pc, 32'h0000_0000);

        // Async reset while suspended in the error state
        cycle("err_flush", 1'b0, 1'b1, 32'h0000_0006);
        cycle("err_entry", 1'b0, 1'b0, 32'h0);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all("async_reset");
        #1;
        rst = 1'b0;
        cycle("re_idle", 1'b0, 1'b0, 32'h0);
        cycle("re_fetch0", 1'b0, 1'b0, 32'h0);
        cycle("re_fetch4", 1'b0, 1'b0, 32'h0);

        // Random stall/flush traffic
        for (int i = 0; i < 400; i++) begin
            st = ($urandom_range(0, 9) < 3);
            fl = ($urandom_range(0, 9) == 0);
            r  = $urandom_range(0, 9);
            if (r < 6) begin
                bt = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
            end else if (r < 8) begin
                bt = 32'hFFFF_FFE0 | {27'd0, 3'($urandom_range(0, 7)), 2'b00};
            end else begin
                bt = $urandom;
            end
            cycle("random", st, fl, bt);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
